seven_seg_scan_controller: RTL and testbench



---
 rtl/seven_seg_scan_controller_if.sv | 14 +
 rtl/seven_seg_scan_controller.sv | 138 +++++++++++++
 tb/tb_seven_seg_scan_controller.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/seven_seg_scan_controller_if.sv
// seven_seg_scan_controller_if: BCD load strobe in, scanned anode/cathode drive out
interface seven_seg_scan_controller_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  logic [4*NUM_DIGITS-1:0] value_in;
  logic                    load;
  logic [NUM_DIGITS-1:0]   an_out;
  logic [6:0]              LED_out;
  logic [IW-1:0]           digit_idx;
  logic                    frame_done;
  modport master (output value_in, load, input an_out, LED_out, digit_idx, frame_done);
  modport slave  (input value_in, load, output an_out, LED_out, digit_idx, frame_done);
endinterface

// File: rtl/seven_seg_scan_controller.sv
// seven_seg_scan_controller: common-anode 7-seg scanner, updates swap in only at frame boundaries (define LEADING_ZERO_BLANK_EN to blank leading zeros)
module seven_seg_scan_controller #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int GAP_CYCLES  = 2
) (
  input logic clk,
  input logic rst_n,
  seven_seg_scan_controller_if.slave bus
);
  localparam int IW   = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int MAXC = REFRESH_DIV > GAP_CYCLES ? REFRESH_DIV : GAP_CYCLES;
  localparam int CW   = MAXC > 1 ? $clog2(MAXC) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] ON_END   = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GAP_END  = CW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, ON, GAP} state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d, next_idx, dig_q;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] disp_q, disp_d, shad_q, shad_d;
  logic                    pend_q, pend_d, boundary;
  logic [NUM_DIGITS-1:0]   an_q, blank;
  logic [6:0]              led_q;
  logic [3:0]              cur;

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0:    seg = 7'b0000001;
      4'd1:    seg = 7'b1001111;
      4'd2:    seg = 7'b0010010;
      4'd3:    seg = 7'b0000110;
      4'd4:    seg = 7'b1001100;
      4'd5:    seg = 7'b0100100;
      4'd6:    seg = 7'b0100000;
      4'd7:    seg = 7'b0001111;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0000100;
      default: seg = 7'b1111111;
    endcase
  endfunction

  assign next_idx       = idx_q == LAST_IDX ? '0 : idx_q + 1'b1;
  assign cur            = disp_q[{idx_q, 2'b00} +: 4];
  assign bus.an_out     = an_q;
  assign bus.LED_out    = led_q;
  assign bus.digit_idx  = dig_q;
  assign bus.frame_done = boundary;

`ifdef LEADING_ZERO_BLANK_EN
  logic z;
  // a digit blanks when it and every digit above it are zero; digit 0 always shows
  always_comb begin
    blank = '0;
    z = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      z = z & (disp_q[4*i +: 4] == 4'd0);
      blank[i] = z;
    end
  end
`else
  assign blank = '0;
`endif

  // scan sequencing plus shadow/display buffering; a load on the boundary bypasses shadow
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    disp_d   = disp_q;
    shad_d   = shad_q;
    pend_d   = pend_q;
    boundary = 1'b0;
    case (state_q)
      IDLE: if (bus.load) begin
        state_d = ON;
        idx_d   = '0;
        cnt_d   = '0;
        disp_d  = bus.value_in;
      end
      ON: if (cnt_q == ON_END) begin
        cnt_d = '0;
        if (GAP_CYCLES > 0) state_d = GAP;
        else begin
          idx_d    = next_idx;
          boundary = idx_q == LAST_IDX;
        end
      end else cnt_d = cnt_q + 1'b1;
      GAP: if (cnt_q == GAP_END) begin
        state_d  = ON;
        cnt_d    = '0;
        idx_d    = next_idx;
        boundary = idx_q == LAST_IDX;
      end else cnt_d = cnt_q + 1'b1;
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && bus.load) begin
      disp_d = boundary ? bus.value_in : disp_q;
      shad_d = boundary ? shad_q : bus.value_in;
      pend_d = !boundary;
    end else if (boundary && pend_q) begin
      disp_d = shad_q;
      pend_d = 1'b0;
    end
  end

  // control and buffer state
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      disp_q  <= '0;
      shad_q  <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      shad_q  <= shad_d;
      pend_q  <= pend_d;
    end

  // anode and cathode registered together so a digit switch never shows a stale pattern
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      an_q  <= '1;
      led_q <= '1;
      dig_q <= '0;
    end else begin
      an_q  <= state_q == ON ? ~(NUM_DIGITS'(1) << idx_q) : '1;
      led_q <= state_q == ON && !blank[idx_q] ? seg(cur) : '1;
      dig_q <= idx_q;
    end
endmodule

// File: tb/tb_seven_seg_scan_controller.sv
// tb_seven_seg_scan_controller: frame-position model plus directed literal checks
module tb_seven_seg_scan_controller;
  localparam int ND = 4, R = 4, G = 1, SLOT = R + G, FRAME = ND * SLOT;
  localparam logic [6:0] SEG [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                      7'b0000000, 7'b0000100, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
  logic clk = 0, rst_n = 0;
  int checks = 0, errors = 0;
  bit m_scan, m_pend;
  int m_pos;
  logic [15:0] m_disp, m_shad;
  logic [3:0] e_an;
  logic [6:0] e_led;
  logic [1:0] e_idx;
  logic e_fd;

  seven_seg_scan_controller_if #(.NUM_DIGITS(ND)) bus ();
  seven_seg_scan_controller #(.NUM_DIGITS(ND), .REFRESH_DIV(R), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] dec(input logic [15:0] v, input int d);
    logic [3:0] n;
    n = v[4*d +: 4];
`ifdef LEADING_ZERO_BLANK_EN
    if (d > 0 && (v >> (4*d)) == 16'd0) return 7'h7F;
`endif
    return SEG[n];
  endfunction

  // model: position within the frame; outputs show the position held before each edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_scan = 0; m_pos = 0; m_disp = 0; m_shad = 0; m_pend = 0;
      e_an = 4'hF; e_led = 7'h7F; e_idx = 0; e_fd = 0;
    end else begin
      e_an  = (m_scan && m_pos % SLOT < R) ? ~(4'b1 << (m_pos / SLOT)) : 4'hF;
      e_led = (m_scan && m_pos % SLOT < R) ? dec(m_disp, m_pos / SLOT) : 7'h7F;
      e_idx = 2'(m_pos / SLOT);
      if (!m_scan) begin
        if (bus.load) begin m_scan = 1; m_pos = 0; m_disp = bus.value_in; end
      end else begin
        if (bus.load && m_pos == FRAME - 1) begin m_disp = bus.value_in; m_pend = 0; end
        else if (bus.load) begin m_shad = bus.value_in; m_pend = 1; end
        else if (m_pos == FRAME - 1 && m_pend) begin m_disp = m_shad; m_pend = 0; end
        m_pos = (m_pos + 1) % FRAME;
      end
      e_fd = m_scan && m_pos == FRAME - 1;
    end
  end

  always @(negedge clk) if (rst_n) begin
    check("an_out", bus.an_out, e_an);
    check("LED_out", bus.LED_out, e_led);
    check("digit_idx", bus.digit_idx, e_idx);
    check("frame_done", bus.frame_done, e_fd);
  end

  task automatic pulse(input logic [15:0] v);
    bus.value_in = v;
    bus.load = 1;
    @(negedge clk);
    bus.load = 0;
  endtask

  task automatic wait_fd();
    int n = 0;
    do begin @(negedge clk); n++; end while (!bus.frame_done && n < 60);
    check("wait_frame_done", bus.frame_done, 1);
  endtask

  task automatic lit(input string name, input logic [3:0] an, input logic [6:0] led);
    check({name, "_an"}, bus.an_out, an);
    check({name, "_led"}, bus.LED_out, led);
  endtask

  initial begin
    int fd_cnt;
    bus.value_in = 0; bus.load = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (50) @(negedge clk);
    lit("idle", 4'hF, 7'h7F);
    pulse(16'h1234);
    @(negedge clk); lit("d0_4", 4'b1110, 7'b1001100);
    check("model_pin_4", e_led, 7'b1001100);
    repeat (4) @(negedge clk); lit("gap0", 4'hF, 7'h7F);
    @(negedge clk); lit("d1_3", 4'b1101, 7'b0000110);
    repeat (5) @(negedge clk); lit("d2_2", 4'b1011, 7'b0010010);
    check("model_pin_2", e_an, 4'b1011);
    repeat (5) @(negedge clk); lit("d3_1", 4'b0111, 7'b1001111);
    fd_cnt = 0;
    repeat (2 * FRAME) begin @(negedge clk); if (bus.frame_done) fd_cnt++; end
    check("fd_per_2frames", fd_cnt, 2);
    wait_fd();
    repeat (2) @(negedge clk);
    repeat (5) @(negedge clk);
    pulse(16'h5678);
    repeat (4) @(negedge clk); lit("old_d2", 4'b1011, 7'b0010010);
    wait_fd();
    repeat (2) @(negedge clk); lit("new_d0_8", 4'b1110, 7'b0000000);
    repeat (3) @(negedge clk);
    pulse(16'h9999);
    repeat (5) @(negedge clk);
    pulse(16'h0000);
    wait_fd();
    repeat (2) @(negedge clk); lit("last_wins_0", 4'b1110, 7'b0000001);
    pulse(16'h00AF);
    wait_fd();
    repeat (2) @(negedge clk); lit("blank_F", 4'b1110, 7'h7F);
    repeat (5) @(negedge clk); lit("blank_A", 4'b1101, 7'h7F);
    repeat (5) @(negedge clk);
`ifdef LEADING_ZERO_BLANK_EN
    lit("lz_d2", 4'b1011, 7'h7F);
    pulse(16'h0070);
    wait_fd();
    repeat (2) @(negedge clk); lit("lz70_d0", 4'b1110, 7'b0000001);
    repeat (5) @(negedge clk); lit("lz70_d1", 4'b1101, 7'b0001111);
    repeat (5) @(negedge clk); lit("lz70_d2", 4'b1011, 7'h7F);
`else
    lit("zero_d2", 4'b1011, 7'b0000001);
`endif
    wait_fd();
    repeat (12) @(negedge clk); lit("pre_rst_d2", 4'b1011, e_led);
    #2 rst_n = 0;
    #1 lit("async_rst", 4'hF, 7'h7F);
    check("async_rst_idx", bus.digit_idx, 0);
    check("async_rst_fd", bus.frame_done, 0);
    #10 rst_n = 1;
    repeat (30) @(negedge clk);
    lit("post_rst_idle", 4'hF, 7'h7F);
    pulse(16'h1234);
    wait_fd();
    bus.value_in = 16'h4321;
    bus.load = 1;
    @(negedge clk);
    bus.load = 0;
    @(negedge clk); lit("bypass_d0_1", 4'b1110, 7'b1001111);
    check("bypass_pending", dut.pend_q, 0);
    repeat (2 * FRAME) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
